int2flt_seq: RTL and testbench
==============================

// Module: int2flt_seq
// PURPOSE
//  Multi-cycle converter: 16-bit sign-magnitude integer -> IEEE-754 half-precision float.
//  Stage directly upstream of the float-to-integer converter. Reads its operand from
//  data memory and writes the float result to the location that stage loads from.
//  Drives the shared data_mem port: combinational read, write on the clock edge.
// PARAMETERS
//  SRC_ADDR  8'd0   address of operand MSB byte (LSB byte at SRC_ADDR+1)
//  DST_ADDR  8'd64  address of result MSB byte (LSB byte at DST_ADDR+1)
// PORTS
//  clk_i        in   1  clock; all state changes on the rising edge
//  reset_ni     in   1  asynchronous, active-low reset
//  start_i      in   1  single-cycle pulse; sampled only in IDLE
//  busy_o       out  1  high in every state except IDLE and DONE
//  done_o       out  1  high in DONE; held until the next accepted start
//  mem_addr_o   out  8  data memory address
//  mem_rd_o     out  1  read enable; high in RD_HI and RD_LO
//  mem_wr_o     out  1  write enable; high in WR_HI and WR_LO only
//  mem_wdata_o  out  8  store data
//  mem_rdata_i  in   8  load data; valid in the same cycle as mem_addr_o
// BEHAVIOUR
//  Reset (async, reset_ni=0): state=IDLE; busy_o=0; done_o=0; mem_wr_o=0; mem_rd_o=0;
//   mem_addr_o=0; mem_wdata_o=0; internal regs=0. Applies immediately, including mid-op.
//   No partial write is completed after reset.
//  FSM: IDLE -> RD_HI -> RD_LO -> NORM -> ROUND -> WR_HI -> WR_LO -> DONE.
//   IDLE/DONE: start_i=1 -> RD_HI, clear done_o. start_i is ignored in all other states.
//   RD_HI: addr=SRC_ADDR; latch sign=rdata[7], mag[14:8]=rdata[6:0].
//   RD_LO: addr=SRC_ADDR+1; latch mag[7:0]; exp<=5'd29.
//   NORM: if mag[14]=1 or mag=0 -> ROUND. Else mag<=mag<<1 and exp<=exp-1; stay in NORM.
//     One shift per cycle, at most 14.
//   ROUND: mant=mag[13:4], guard=mag[3], sticky=|mag[2:0].
//     Round to nearest even: up iff guard & (sticky | mant[0]).
//     If mant=10'h3FF and round up -> mant=0, exp=exp+1 (max exp 30; no overflow possible).
//     If mag=0 -> result={sign,15'b0} (signed zero preserved).
//     Else result={sign,exp,mant}.
//   WR_HI: addr=DST_ADDR, wdata=result[15:8], wr=1.
//   WR_LO: addr=DST_ADDR+1, wdata=result[7:0], wr=1.
//   DONE: done_o=1, busy_o=0; memory port idle (rd=0, wr=0).
//  Latency: done_o rises 6+k clock edges after the start edge.
//   k = number of NORM shifts = 14 - msb_index(mag); k=0 for mag=0.
//   Minimum 6 (mag>=16384 or zero); maximum 20 (mag=1).
//  Widths: mag 15 bits, exp 5 bits unsigned; no value wraps in legal operation.
//  Back-to-back start in DONE starts a new conversion; done_o drops the next cycle.
// TESTING
//  mem[0:1]=00 01, start -> mem[64:65]=3C 00; done_o 20 edges after start.
//  mem[0:1]=80 01 -> BC 00 (sign carried through).
//  mem[0:1]=7F FF -> 78 00: rounding carry bumps exp to 30; latency 6.
//  mem[0:1]=08 01 -> 68 00 (tie, rounds to even); 08 03 -> 68 02 (tie, rounds up).
//  mem[0:1]=80 00 -> 80 00, latency 6.
//  Control: pulse start_i while busy -> ignored, no extra write.
//   Reset mid-NORM -> outputs at reset values at once, mem[64:65] unchanged.
//   Restart after reset -> correct result.

Source files
------------

// File: rtl/int2flt_seq.sv
// Sequential 16-bit sign-magnitude integer to IEEE-754 half-precision converter.
// It reads the operand bytes from data memory, normalises one bit per cycle, rounds, and writes the two result bytes back.
module int2flt_seq #(
    parameter logic [7:0] SRC_ADDR = 8'd0,
    parameter logic [7:0] DST_ADDR = 8'd64
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       start_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] mem_addr_o,
    output logic       mem_rd_o,
    output logic       mem_wr_o,
    output logic [7:0] mem_wdata_o,
    input  logic [7:0] mem_rdata_i
);
    typedef enum logic [2:0] {
        IDLE, RD_HI, RD_LO, NORM, ROUND, WR_HI, WR_LO, DONE
    } state_t;

    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic [14:0] mag_q, mag_d;
    logic [4:0]  exp_q, exp_d;
    logic [15:0] res_q, res_d;

    // Round to nearest even. A carry out of the mantissa rolls it to zero and bumps the exponent.
    logic [9:0]  mant;
    logic        guard, sticky, rnd_up;
    logic [10:0] mant_sum;
    logic [4:0]  exp_rnd;

    always_comb begin
        mant     = mag_q[13:4];
        guard    = mag_q[3];
        sticky   = |mag_q[2:0];
        rnd_up   = guard & (sticky | mant[0]);
        mant_sum = {1'b0, mant} + {10'd0, rnd_up};
        exp_rnd  = exp_q + {4'd0, mant_sum[10]};
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            mag_q   <= '0;
            exp_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            mag_q   <= mag_d;
            exp_q   <= exp_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        mag_d       = mag_q;
        exp_d       = exp_q;
        res_d       = res_q;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        mem_addr_o  = 8'd0;
        mem_rd_o    = 1'b0;
        mem_wr_o    = 1'b0;
        mem_wdata_o = 8'd0;
        case (state_q)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i) state_d = RD_HI;
            end
            RD_HI: begin
                mem_addr_o  = SRC_ADDR;
                mem_rd_o    = 1'b1;
                sign_d      = mem_rdata_i[7];
                mag_d[14:8] = mem_rdata_i[6:0];
                state_d     = RD_LO;
            end
            RD_LO: begin
                mem_addr_o = SRC_ADDR + 8'd1;
                mem_rd_o   = 1'b1;
                mag_d[7:0] = mem_rdata_i;
                exp_d      = 5'd29;
                state_d    = NORM;
            end
            NORM: begin
                if (mag_q[14] || (mag_q == '0)) begin
                    state_d = ROUND;
                end else begin
                    mag_d = {mag_q[13:0], 1'b0};
                    exp_d = exp_q - 5'd1;
                end
            end
            ROUND: begin
                if (mag_q == '0) res_d = {sign_q, 15'd0};
                else             res_d = {sign_q, exp_rnd, mant_sum[9:0]};
                state_d = WR_HI;
            end
            WR_HI: begin
                mem_addr_o  = DST_ADDR;
                mem_wr_o    = 1'b1;
                mem_wdata_o = res_q[15:8];
                state_d     = WR_LO;
            end
            WR_LO: begin
                mem_addr_o  = DST_ADDR + 8'd1;
                mem_wr_o    = 1'b1;
                mem_wdata_o = res_q[7:0];
                state_d     = DONE;
            end
            DONE: begin
                busy_o = 1'b0;
                done_o = 1'b1;
                if (start_i) state_d = RD_HI;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_int2flt_seq.sv
// Bench for int2flt_seq: byte memory model, table vectors, random operands against an arithmetic reference, control corner cases.
module tb_int2flt_seq;
    logic       clk_i = 1'b0;
    logic       reset_ni;
    logic       start_i;
    logic       busy_o, done_o, mem_rd_o, mem_wr_o;
    logic [7:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    logic [7:0] mem [0:255];
    int         wr_cnt = 0;
    int         nvec = 0;
    int         nerr = 0;

    int2flt_seq dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .start_i(start_i),
        .busy_o(busy_o), .done_o(done_o), .mem_addr_o(mem_addr_o),
        .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    assign mem_rdata_i = mem[mem_addr_o];

    always @(posedge clk_i) begin
        if (mem_wr_o) begin
            mem[mem_addr_o] <= mem_wdata_o;
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: value = mag, exponent = 15 + msb index, mantissa rounded to 11 significant bits.
    task automatic ref_conv(input logic [15:0] x, output logic [15:0] r, output int lat);
        int m, e, q, sh, rem, half, ex;
        m = int'(x[14:0]);
        if (m == 0) begin
            r   = {x[15], 15'd0};
            lat = 6;
            return;
        end
        e = 0;
        for (int i = 0; i < 15; i++) if ((m >> i) & 1) e = i;
        lat = 6 + (14 - e);
        ex  = 15 + e;
        if (e >= 10) begin
            sh   = e - 10;
            q    = m >> sh;
            rem  = m - (q << sh);
            half = (sh == 0) ? 0 : (1 << (sh - 1));
            if (sh != 0 && (rem > half || (rem == half && (q & 1) == 1))) q = q + 1;
        end else begin
            q = m << (10 - e);
        end
        if (q == 2048) begin
            q  = 1024;
            ex = ex + 1;
        end
        r = {x[15], 5'(ex), 10'(q)};
    endtask

    // One conversion from IDLE/DONE; optionally pulses start while busy.
    task automatic run_conv(input string tag, input logic [7:0] hi, input logic [7:0] lo,
                            input logic [15:0] exp_r, input int exp_lat, input bit poke);
        int n, w0;
        bit busy_ok;
        mem[0] = hi;
        mem[1] = lo;
        w0 = wr_cnt;
        @(negedge clk_i);
        start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        chk({tag, " done_drop"}, int'(done_o), 0);
        n = 0;
        busy_ok = 1'b1;
        while (!done_o && n < 100) begin
            if (!busy_o) busy_ok = 1'b0;
            if (poke && (n == 2 || n == 4)) start_i = 1'b1;
            @(posedge clk_i);
            #1 start_i = 1'b0;
            n++;
        end
        chk({tag, " latency"}, n, exp_lat);
        chk({tag, " result"}, int'({mem[64], mem[65]}), int'(exp_r));
        chk({tag, " writes"}, wr_cnt - w0, 2);
        chk({tag, " busy"}, int'(busy_ok), 1);
    endtask

    typedef struct {
        logic [7:0]  hi, lo;
        logic [15:0] res;
        int          lat;
    } vec_t;

    initial begin
        vec_t        tbl [6];
        logic [15:0] r;
        int          lat, w0;
        logic [7:0]  h, l;

        tbl[0] = '{8'h00, 8'h01, 16'h3C00, 20};
        tbl[1] = '{8'h80, 8'h01, 16'hBC00, 20};
        tbl[2] = '{8'h7F, 8'hFF, 16'h7800, 6};
        tbl[3] = '{8'h08, 8'h01, 16'h6800, 9};
        tbl[4] = '{8'h08, 8'h03, 16'h6802, 9};
        tbl[5] = '{8'h80, 8'h00, 16'h8000, 6};

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        start_i  = 1'b0;
        reset_ni = 1'b0;
        #1;
        chk("reset outputs", int'({busy_o, done_o, mem_rd_o, mem_wr_o, mem_addr_o, mem_wdata_o}), 0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i) reset_ni = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_conv($sformatf("tbl%0d", i), tbl[i].hi, tbl[i].lo, tbl[i].res, tbl[i].lat, 1'b0);
            ref_conv({tbl[i].hi, tbl[i].lo}, r, lat);
            chk($sformatf("model%0d", i), int'(r), int'(tbl[i].res));
        end

        run_conv("poke", 8'h00, 8'h05, 16'h4500, 18, 1'b1);

        for (int i = 0; i < 40; i++) begin
            h = 8'($urandom);
            l = 8'($urandom);
            case (i % 4)
                1: h = h & 8'h80;
                2: h = h & 8'h83;
                default: ;
            endcase
            ref_conv({h, l}, r, lat);
            run_conv($sformatf("rnd%0d", i), h, l, r, lat, (i % 8) == 3);
        end

        // Reset in the middle of normalisation
        mem[64] = 8'hA5;
        mem[65] = 8'h5A;
        mem[0]  = 8'h00;
        mem[1]  = 8'h01;
        w0 = wr_cnt;
        @(negedge clk_i) start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #2 reset_ni = 1'b0;
        #1;
        chk("midreset outputs", int'({busy_o, done_o, mem_rd_o, mem_wr_o, mem_addr_o, mem_wdata_o}), 0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i) reset_ni = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("midreset idle", int'({busy_o, done_o}), 0);
        chk("midreset mem", int'({mem[64], mem[65]}), 16'hA55A);
        chk("midreset writes", wr_cnt - w0, 0);

        run_conv("restart", 8'h00, 8'h01, 16'h3C00, 20, 1'b0);
        run_conv("b2b", 8'h7F, 8'hFF, 16'h7800, 6, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
